motor_status_tx: RTL and testbench

MOTOR_STATUS_TX -- requirements
Module: motor_status_tx

---
 rtl/motor_status_tx.sv | 90 +++++++++
 tb/tb_motor_status_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/motor_status_tx.sv
// UART reporter for motor status: whenever {accion, ubicacion} differs from the
// last report sent, transmits a 3-byte ASCII message (code, position, newline).
module motor_status_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] accion,
  input  logic       ubicacion,
  output logic       tx,
  output logic       busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_n;
  logic [2:0]      last_sent;
  logic [3:0][7:0] msg;        // entry 3 is unused padding so idx never selects out of range
  logic [1:0]      idx;
  logic [2:0]      bit_idx;
  logic [CW-1:0]   cnt;
  logic [2:0]      report;
  logic            bit_end;
  logic            report_new;
  logic [7:0]      byte0;

  assign report     = {accion, ubicacion};
  assign bit_end    = (cnt == CW'(CLKS_PER_BIT - 1));
  assign report_new = (report != last_sent);

  always_comb begin
    case (accion)
      2'b00:   byte0 = 8'h53;
      2'b10:   byte0 = 8'h55;
      2'b01:   byte0 = 8'h44;
      default: byte0 = 8'h45;
    endcase
  end

  always_comb begin
    state_n = state;
    tx      = 1'b1;
    busy    = (state != IDLE);
    case (state)
      IDLE:  if (report_new) state_n = START;
      START: begin
        tx = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx = msg[idx][bit_idx];
        if (bit_end && bit_idx == 3'd7) state_n = STOP;
      end
      STOP:  if (bit_end) state_n = (idx == 2'd2) ? IDLE : START;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_sent <= 3'b000;
      msg       <= '0;
      idx       <= 2'd0;
      bit_idx   <= 3'd0;
      cnt       <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE) begin
        cnt     <= '0;
        bit_idx <= 3'd0;
        // Snapshot the inputs once; the message stays frozen until IDLE is re-entered.
        if (report_new) begin
          last_sent <= report;
          msg       <= {8'h00, 8'h0A, (ubicacion ? 8'h31 : 8'h30), byte0};
          idx       <= 2'd0;
        end
      end else begin
        cnt <= bit_end ? '0 : cnt + 1'b1;
        if (state == DATA && bit_end) bit_idx <= bit_idx + 3'd1;
        if (state == STOP && bit_end && idx != 2'd2) idx <= idx + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_motor_status_tx.sv
// Bench for motor_status_tx: waveform-queue reference model checked every cycle,
// table of reports decoded off the line, and hand sequences for mid-message events.
module tb_motor_status_tx;

  localparam int CPB = 4;
  localparam int MSG = 30 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] accion = 2'b00;
  logic       ubicacion = 1'b0;
  logic       tx, busy;

  always #5 clk = ~clk;

  motor_status_tx #(.CLK_HZ(4), .BAUD(1)) dut (
    .clk(clk), .rst(rst), .accion(accion), .ubicacion(ubicacion), .tx(tx), .busy(busy)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  logic mq[$];          // expected tx level for each remaining cycle of the message
  logic [2:0] m_last = 3'b000;
  logic cap[$];

  typedef struct {
    logic [1:0] a;
    logic       u;
    logic [7:0] e0;
    logic [7:0] e1;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [7:0] code_byte(input logic [1:0] a);
    case (a)
      2'b00:   return 8'h53;
      2'b10:   return 8'h55;
      2'b01:   return 8'h44;
      default: return 8'h45;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    repeat (CPB) mq.push_back(1'b0);
    for (int j = 0; j < 8; j++) repeat (CPB) mq.push_back(b[j]);
    repeat (CPB) mq.push_back(1'b1);
  endtask

  // One clock: update the model with the inputs seen at the edge, then compare.
  task automatic cycle();
    logic etx, ebusy;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_last = 3'b000;
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
    end else if ({accion, ubicacion} != m_last) begin
      m_last = {accion, ubicacion};
      push_byte(code_byte(accion));
      push_byte(ubicacion ? 8'h31 : 8'h30);
      push_byte(8'h0A);
    end
    @(negedge clk);
    ebusy = (mq.size() != 0);
    etx   = 1'b1;
    if (ebusy) etx = mq[0];
    check("line_vs_model", {30'd0, busy, tx}, {30'd0, ebusy, etx});
  endtask

  task automatic run_msg(input string name, input logic [7:0] e0, input logic [7:0] e1,
                         input int at1, input logic [2:0] v1, input int at2, input logic [2:0] v2);
    int w;
    logic [7:0] exp_b[3];
    logic [7:0] b;
    int stops;
    exp_b[0] = e0; exp_b[1] = e1; exp_b[2] = 8'h0A;
    w = 0;
    cap.delete();
    while (!busy && w < 10) begin cycle(); w++; end
    check({name, "_latency"}, w, 1);
    while (busy && cap.size() < 200) begin
      if (cap.size() == at1) {accion, ubicacion} = v1;
      if (cap.size() == at2) {accion, ubicacion} = v2;
      cap.push_back(tx);
      cycle();
    end
    check({name, "_busy_len"}, cap.size(), MSG);
    if (cap.size() >= MSG) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 8; j++) b[j] = cap[40*k + CPB*(j+1) + 1];
        check($sformatf("%s_byte%0d", name, k), b, exp_b[k]);
        check($sformatf("%s_start%0d", name, k), cap[40*k + 1], 0);
        stops = 0;
        for (int c = 0; c < CPB; c++) stops += cap[40*k + 36 + c];
        check($sformatf("%s_stop%0d", name, k), stops, CPB);
      end
    end
  endtask

  initial begin
    int nb, nl;

    tbl[0] = '{2'b10, 1'b0, 8'h55, 8'h30};
    tbl[1] = '{2'b11, 1'b0, 8'h45, 8'h30};
    tbl[2] = '{2'b01, 1'b1, 8'h44, 8'h31};
    tbl[3] = '{2'b00, 1'b1, 8'h53, 8'h31};
    tbl[4] = '{2'b10, 1'b1, 8'h55, 8'h31};
    tbl[5] = '{2'b01, 1'b0, 8'h44, 8'h30};
    tbl[6] = '{2'b11, 1'b1, 8'h45, 8'h31};
    tbl[7] = '{2'b00, 1'b0, 8'h53, 8'h30};

    // Reset and a long quiet period with the default report
    rst = 1'b1;
    repeat (3) cycle();
    check("reset_tx_busy", {30'd0, tx, busy}, 32'b10);
    rst = 1'b0;
    nb = 0; nl = 0;
    repeat (500) begin cycle(); nb += busy; nl += !tx; end
    check("idle500_busy", nb, 0);
    check("idle500_txlow", nl, 0);

    // Every report code/position, decoded off the line
    for (int i = 0; i < 8; i++) begin
      accion = tbl[i].a; ubicacion = tbl[i].u;
      run_msg($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, -1, 3'b0, -1, 3'b0);
    end

    // Position changes mid-message: first unchanged, second follows right away
    accion = 2'b10; ubicacion = 1'b0;
    run_msg("mid_change_a", 8'h55, 8'h30, 50, 3'b101, -1, 3'b0);
    run_msg("mid_change_b", 8'h55, 8'h31, -1, 3'b0, -1, 3'b0);

    // Toggle away and back within one message: nothing further is sent
    ubicacion = 1'b0;
    run_msg("toggle_back", 8'h55, 8'h30, 20, 3'b000, 60, 3'b100);
    nb = 0;
    repeat (30) begin cycle(); nb += busy; end
    check("toggle_back_quiet", nb, 0);

    // Reset part-way through a frame, then a fresh report
    accion = 2'b11; ubicacion = 1'b0;
    cycle();
    check("abort_started", busy, 1);
    repeat (36) cycle();
    rst = 1'b1;
    cycle();
    check("abort_tx_busy", {30'd0, tx, busy}, 32'b10);
    accion = 2'b01; ubicacion = 1'b1; rst = 1'b0;
    run_msg("after_abort", 8'h44, 8'h31, -1, 3'b0, -1, 3'b0);

    // Random input changes and occasional resets against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 24) == 0) begin
        accion = 2'($urandom_range(0, 3));
        ubicacion = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 399) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
